// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI slave responder.
// Mode is fixed at CPOL=1, CPHA=1: drive on falling SCLK, sample on rising SCLK.
package spi_pkg;

  localparam logic CPOL = 1'b1;
  localparam logic CPHA = 1'b1;

  localparam int DEFAULT_DATABITS = 8;
  localparam logic [7:0] DEFAULT_UNDERRUN_FILL = 8'hFF;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_t;

endpackage

// File: rtl/spi_in_sync.sv
// Multi-flop synchroniser with a history flop and edge outputs.
// Used for every SPI pad input so all three see identical latency.
module spi_in_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= {STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
    end
  end

  assign sync = chain[STAGES-1];
  assign rise = ~prev & sync;
  assign fall = prev & ~sync;

endmodule

// File: rtl/spi_slave_responder.sv
// SPI target (CPOL=1, CPHA=1, MSB first) with valid/ready tx and rx byte streams
// and sticky underrun/overrun/abort status.
module spi_slave_responder
  import spi_pkg::*;
#(
  parameter int                    DATABITS      = DEFAULT_DATABITS,
  parameter int                    SYNC_STAGES   = 2,
  parameter logic [DATABITS-1:0]   UNDERRUN_FILL = DATABITS'(DEFAULT_UNDERRUN_FILL)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                SCLK,
  input  logic                SS_n,
  input  logic                MOSI,
  output logic                MISO,
  output logic                MISO_oe,
  input  logic [DATABITS-1:0] tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic [DATABITS-1:0] rx_data,
  output logic                rx_valid,
  input  logic                rx_ready,
  output logic                busy,
  output logic                tx_underrun,
  output logic                rx_overrun,
  output logic                frame_abort,
  input  logic                clear_status
);

  localparam int CW = (DATABITS > 1) ? $clog2(DATABITS) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATABITS - 1);

  logic sclk_s, sclk_rise, sclk_fall;
  logic ss_s, unused_ss_rise, unused_ss_fall;
  logic mosi_s, unused_mosi_rise, unused_mosi_fall;

  spi_in_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sclk (
    .clk(clk), .reset(reset), .din(SCLK), .sync(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_in_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clk(clk), .reset(reset), .din(SS_n), .sync(ss_s), .rise(unused_ss_rise), .fall(unused_ss_fall)
  );
  spi_in_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .din(MOSI), .sync(mosi_s), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
  );

  spi_state_t state, state_next;
  logic [CW-1:0]       bitcnt;
  logic [DATABITS-1:0] shift_reg;
  logic [DATABITS-1:0] tx_hold;
  logic                tx_primed;
  logic [SYNC_STAGES:0] settle;
  logic                armed;

  // Synchroniser reset values mimic a deselected bus, so SS_n is only trusted
  // once the chain has flushed and a real high level has been seen; a master
  // still holding SS_n low across a reset must toggle it before we re-engage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      settle <= '0;
      armed  <= 1'b0;
    end else begin
      settle <= {settle[SYNC_STAGES-1:0], 1'b1};
      if (settle[SYNC_STAGES] && ss_s) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (armed && !ss_s) state_next = ACTIVE;
      ACTIVE:  if (ss_s)           state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  logic                active, in_frame, load_evt, word_done, abort_evt, tx_write;
  logic [DATABITS-1:0] load_word;

  assign active    = (state == ACTIVE);
  assign in_frame  = active & ~ss_s;
  assign load_evt  = in_frame & sclk_fall & (bitcnt == '0);
  assign word_done = in_frame & sclk_rise & (bitcnt == LAST_BIT);
  assign abort_evt = active & ss_s & (bitcnt != '0);
  assign tx_write  = tx_valid & ~tx_primed;
  assign load_word = tx_primed ? tx_hold : UNDERRUN_FILL;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      MISO        <= 1'b1;
      bitcnt      <= '0;
      shift_reg   <= '0;
      tx_hold     <= '0;
      tx_primed   <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      rx_overrun  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      // A write can only land while empty, so it never races a consuming load.
      if (tx_write) begin
        tx_hold   <= tx_data;
        tx_primed <= 1'b1;
      end else if (load_evt && tx_primed) begin
        tx_primed <= 1'b0;
      end

      if (load_evt) begin
        shift_reg <= load_word;
        MISO      <= load_word[DATABITS-1];
      end else if (in_frame && sclk_fall) begin
        MISO <= shift_reg[DATABITS-1];
      end else if (!active) begin
        MISO <= 1'b1;
      end

      if (in_frame && sclk_rise) begin
        shift_reg <= {shift_reg[DATABITS-2:0], mosi_s};
        bitcnt    <= word_done ? '0 : bitcnt + 1'b1;
      end else if (active && ss_s) begin
        bitcnt <= '0;
      end

      if (word_done) begin
        rx_data  <= {shift_reg[DATABITS-2:0], mosi_s};
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      tx_underrun <= (load_evt & ~tx_primed) | (tx_underrun & ~clear_status);
      rx_overrun  <= (word_done & rx_valid & ~rx_ready) | (rx_overrun & ~clear_status);
      frame_abort <= abort_evt | (frame_abort & ~clear_status);
    end
  end

  assign tx_ready = ~tx_primed;
  assign busy     = active;
  assign MISO_oe  = active;

endmodule
